// File: rtl/hbridge_guard_pkg.sv
// hbridge_pkg: shared definitions for the H-bridge guard.
//   state_e   per-channel FSM states (IDLE, RAMP, RUN, DEAD)
//   DIR_*     direction codes of one bridge pin pair
//   is_move   true for FWD or REV, false for the STOP codes (coast, brake)
//   cnt_w     counter width for a modulus n, never less than one bit
package hbridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2,
    DEAD = 2'd3
  } state_e;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  function automatic logic is_move(input logic [1:0] code);
    return (code == DIR_FWD) || (code == DIR_REV);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hbridge_guard_if.sv
// hbridge_guard_if: motor-drive bundle between the PWM stage and the guard.
//   ena_in/enb_in  raw channel enables from the PWM stage
//   in_req[3:0]    raw direction request ([1:0] channel A, [3:2] channel B)
//   halt           over-current halt level
//   ena/enb/in     guarded bridge pins
//   busy[1:0]      per channel, high while in DEAD or RAMP
// slave modport: the guard; master modport: the side driving the requests.
interface hbridge_guard_if;
  logic       ena_in;
  logic       enb_in;
  logic [3:0] in_req;
  logic       halt;
  logic       ena;
  logic       enb;
  logic [3:0] in;
  logic [1:0] busy;

  modport slave (
    input  ena_in, enb_in, in_req, halt,
    output ena, enb, in, busy
  );

  modport master (
    output ena_in, enb_in, in_req, halt,
    input  ena, enb, in, busy
  );
endinterface

// File: rtl/hbridge_guard_channel.sv
// hbridge_channel: guard FSM for one bridge channel.
//   clk, clr_n  clock and asynchronous active-low reset
//   en_in, req  raw enable and direction pair from the PWM stage
//   halt        over-current halt, forces IDLE while high
//   saw         shared gating sawtooth
//   pair_o, en_o, busy_o  unregistered next-cycle pin values; the top
//               registers them. They are derived from the state being
//               entered so a transition shows on the pins one cycle later.
module hbridge_channel
  import hbridge_pkg::*;
#(
  parameter int PERIOD      = 1000,
  parameter int DEAD_CYCLES = 50000,
  parameter int STEP_CYCLES = 100000,
  parameter int RAMP_INC    = 50
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      en_in,
  input  logic [1:0]                req,
  input  logic                      halt,
  input  logic [cnt_w(PERIOD)-1:0]  saw,
  output logic [1:0]                pair_o,
  output logic                      en_o,
  output logic                      busy_o
);

  localparam int SAW_W  = cnt_w(PERIOD);
  localparam int LVL_W  = SAW_W + 1;
  localparam int DEAD_W = cnt_w(DEAD_CYCLES);
  localparam int STEP_W = cnt_w(STEP_CYCLES);

  localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(PERIOD);
  localparam logic [LVL_W-1:0]  LVL_INC   = LVL_W'(RAMP_INC);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        dir_q, dir_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DEAD_W-1:0] dead_q, dead_d;

  logic [LVL_W:0]    level_sum_s;
  logic [LVL_W-1:0]  level_sat_s;

  // Next ramp level, clamped at the sawtooth period.
  always_comb begin
    level_sum_s = {1'b0, level_q} + {1'b0, LVL_INC};
    if (level_sum_s >= {1'b0, LVL_MAX}) begin
      level_sat_s = LVL_MAX;
    end else begin
      level_sat_s = level_sum_s[LVL_W-1:0];
    end
  end

  // Next-state logic; halt is checked first so it beats every transition,
  // and the reversal test precedes the ramp step so reversal beats saturation.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    level_d = level_q;
    step_d  = step_q;
    dead_d  = dead_q;
    if (halt) begin
      state_d = IDLE;
      level_d = {LVL_W{1'b0}};
      step_d  = {STEP_W{1'b0}};
      dead_d  = {DEAD_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          level_d = {LVL_W{1'b0}};
          step_d  = {STEP_W{1'b0}};
          if (is_move(req)) begin
            state_d = RAMP;
            dir_d   = req;
          end else begin
            state_d = IDLE;
          end
        end
        RAMP, RUN: begin
          if (is_move(req) && (req != dir_q)) begin
            state_d = DEAD;
            dir_d   = req;
            dead_d  = DEAD_LOAD;
          end else if (!is_move(req)) begin
            state_d = IDLE;
            level_d = {LVL_W{1'b0}};
            step_d  = {STEP_W{1'b0}};
          end else if (state_q == RAMP) begin
            if (step_q == STEP_LAST) begin
              step_d  = {STEP_W{1'b0}};
              level_d = level_sat_s;
              if (level_sat_s == LVL_MAX) begin
                state_d = RUN;
              end else begin
                state_d = RAMP;
              end
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end else begin
            state_d = RUN;
          end
        end
        DEAD: begin
          // The count keeps running while the request changes; only the
          // latched direction follows it.
          if (is_move(req)) begin
            dir_d = req;
          end else begin
            dir_d = dir_q;
          end
          if (dead_q == {DEAD_W{1'b0}}) begin
            level_d = {LVL_W{1'b0}};
            step_d  = {STEP_W{1'b0}};
            if (is_move(req)) begin
              state_d = RAMP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            dead_d = dead_q - DEAD_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          level_d = {LVL_W{1'b0}};
          step_d  = {STEP_W{1'b0}};
          dead_d  = {DEAD_W{1'b0}};
        end
      endcase
    end
  end

  // Pin values for the state being entered.
  always_comb begin
    pair_o = DIR_COAST;
    en_o   = 1'b0;
    busy_o = 1'b0;
    if (halt) begin
      pair_o = DIR_COAST;
      en_o   = 1'b0;
      busy_o = 1'b0;
    end else begin
      case (state_d)
        IDLE: begin
          pair_o = req;
          en_o   = en_in;
        end
        RAMP: begin
          pair_o = dir_d;
          en_o   = en_in && (LVL_W'(saw) < level_d);
          busy_o = 1'b1;
        end
        RUN: begin
          pair_o = dir_d;
          en_o   = en_in;
        end
        DEAD: begin
          busy_o = 1'b1;
        end
        default: begin
          pair_o = DIR_COAST;
        end
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_COAST;
      level_q <= {LVL_W{1'b0}};
      step_q  <= {STEP_W{1'b0}};
      dead_q  <= {DEAD_W{1'b0}};
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      level_q <= level_d;
      step_q  <= step_d;
      dead_q  <= dead_d;
    end
  end

endmodule

// File: rtl/hbridge_guard.sv
// hbridge_guard: dead-time, soft-start and halt guard for a dual H-bridge.
//   clk    system clock
//   clr_n  asynchronous active-low reset
//   bus    hbridge_guard_if.slave: raw PWM-stage inputs in, guarded pins out
// Holds the shared sawtooth, both channel guards and the output registers.
module hbridge_guard
  import hbridge_pkg::*;
#(
  parameter int PERIOD      = 1000,
  parameter int DEAD_CYCLES = 50000,
  parameter int STEP_CYCLES = 100000,
  parameter int RAMP_INC    = 50
) (
  input  logic           clk,
  input  logic           clr_n,
  hbridge_guard_if.slave bus
);

  localparam int SAW_W = cnt_w(PERIOD);
  localparam logic [SAW_W-1:0] SAW_LAST = SAW_W'(PERIOD - 1);

  logic [SAW_W-1:0] saw_q, saw_d;
  logic [1:0]       a_pair_s, b_pair_s;
  logic             a_en_s, b_en_s, a_busy_s, b_busy_s;
  logic             ena_q, ena_d, enb_q, enb_d;
  logic [3:0]       in_q, in_d;
  logic [1:0]       busy_q, busy_d;

  // Free-running gating sawtooth, 0..PERIOD-1.
  always_comb begin
    if (saw_q == SAW_LAST) begin
      saw_d = {SAW_W{1'b0}};
    end else begin
      saw_d = saw_q + SAW_W'(1);
    end
  end

  hbridge_channel #(
    .PERIOD(PERIOD), .DEAD_CYCLES(DEAD_CYCLES),
    .STEP_CYCLES(STEP_CYCLES), .RAMP_INC(RAMP_INC)
  ) u_ch_a (
    .clk(clk), .clr_n(clr_n), .en_in(bus.ena_in), .req(bus.in_req[1:0]),
    .halt(bus.halt), .saw(saw_q),
    .pair_o(a_pair_s), .en_o(a_en_s), .busy_o(a_busy_s)
  );

  hbridge_channel #(
    .PERIOD(PERIOD), .DEAD_CYCLES(DEAD_CYCLES),
    .STEP_CYCLES(STEP_CYCLES), .RAMP_INC(RAMP_INC)
  ) u_ch_b (
    .clk(clk), .clr_n(clr_n), .en_in(bus.enb_in), .req(bus.in_req[3:2]),
    .halt(bus.halt), .saw(saw_q),
    .pair_o(b_pair_s), .en_o(b_en_s), .busy_o(b_busy_s)
  );

  // Gather both channels into the output register inputs.
  always_comb begin
    ena_d  = a_en_s;
    enb_d  = b_en_s;
    in_d   = {b_pair_s, a_pair_s};
    busy_d = {b_busy_s, a_busy_s};
  end

  // Sawtooth and bridge pin registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      saw_q  <= {SAW_W{1'b0}};
      ena_q  <= 1'b0;
      enb_q  <= 1'b0;
      in_q   <= 4'b0000;
      busy_q <= 2'b00;
    end else begin
      saw_q  <= saw_d;
      ena_q  <= ena_d;
      enb_q  <= enb_d;
      in_q   <= in_d;
      busy_q <= busy_d;
    end
  end

  assign bus.ena  = ena_q;
  assign bus.enb  = enb_q;
  assign bus.in   = in_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_hbridge_guard.sv
// Scoreboard bench for hbridge_guard with a behavioural reference model.
module tb_hbridge_guard;

  localparam int PERIOD = 10;
  localparam int DEAD   = 4;
  localparam int STEP   = 2;
  localparam int INC    = 5;

  localparam int M_IDLE = 0;
  localparam int M_RAMP = 1;
  localparam int M_RUN  = 2;
  localparam int M_DEAD = 3;

  typedef struct packed {
    logic       ena;
    logic       enb;
    logic [3:0] pins;
    logic [1:0] busy;
  } out_t;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  out_t exp_q[$];

  // Reference model: per channel mode, direction, cycles spent ramping,
  // remaining dead cycles; plus the shared sawtooth value.
  int         m_mode[2];
  logic [1:0] m_dir[2];
  int         m_age[2];
  int         m_dead[2];
  int         m_saw;

  hbridge_guard_if bus();

  hbridge_guard #(
    .PERIOD(PERIOD), .DEAD_CYCLES(DEAD), .STEP_CYCLES(STEP), .RAMP_INC(INC)
  ) dut (
    .clk(clk), .clr_n(clr_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int lvl(input int age);
    int v;
    v = INC * (age / STEP);
    return (v > PERIOD) ? PERIOD : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = M_IDLE;
      m_dir[c]  = 2'b00;
      m_age[c]  = 0;
      m_dead[c] = 0;
    end
    m_saw = 0;
  endtask

  task automatic model_chan(input int c, input logic en_in, input logic [1:0] req,
                            input logic hlt, output logic [1:0] pair,
                            output logic en, output logic bsy);
    bit mv;
    mv = (req == 2'b10) || (req == 2'b01);
    if (hlt) begin
      m_mode[c] = M_IDLE;
    end else if (m_mode[c] == M_IDLE) begin
      if (mv) begin
        m_mode[c] = M_RAMP; m_dir[c] = req; m_age[c] = 0;
      end
    end else if (m_mode[c] == M_DEAD) begin
      if (mv) m_dir[c] = req;
      m_dead[c] = m_dead[c] - 1;
      if (m_dead[c] == 0) begin
        if (mv) begin
          m_mode[c] = M_RAMP; m_age[c] = 0;
        end else begin
          m_mode[c] = M_IDLE;
        end
      end
    end else begin
      if (mv && req != m_dir[c]) begin
        m_mode[c] = M_DEAD; m_dir[c] = req; m_dead[c] = DEAD;
      end else if (!mv) begin
        m_mode[c] = M_IDLE;
      end else if (m_mode[c] == M_RAMP) begin
        m_age[c] = m_age[c] + 1;
        if (lvl(m_age[c]) == PERIOD) m_mode[c] = M_RUN;
      end
    end
    pair = 2'b00; en = 1'b0; bsy = 1'b0;
    if (!hlt) begin
      case (m_mode[c])
        M_IDLE: begin pair = req; en = en_in; end
        M_RAMP: begin pair = m_dir[c]; en = en_in && (m_saw < lvl(m_age[c])); bsy = 1'b1; end
        M_RUN:  begin pair = m_dir[c]; en = en_in; end
        default: begin bsy = 1'b1; end
      endcase
    end
  endtask

  // Drive one cycle of inputs (no waiting) and queue the expected response.
  task automatic apply(input logic ea, input logic eb, input logic [3:0] rq, input logic h);
    out_t e;
    logic [1:0] pa, pb;
    logic xa, xb, ba, bb;
    bus.ena_in = ea; bus.enb_in = eb; bus.in_req = rq; bus.halt = h;
    model_chan(0, ea, rq[1:0], h, pa, xa, ba);
    model_chan(1, eb, rq[3:2], h, pb, xb, bb);
    e.ena = xa; e.enb = xb; e.pins = {pb, pa}; e.busy = {bb, ba};
    exp_q.push_back(e);
    m_saw = (m_saw + 1) % PERIOD;
  endtask

  task automatic step(input logic ea, input logic eb, input logic [3:0] rq, input logic h);
    @(negedge clk);
    apply(ea, eb, rq, h);
  endtask

  task automatic check_now(input string name, input out_t exp);
    out_t got;
    got = {bus.ena, bus.enb, bus.in, bus.busy};
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ena=%b enb=%b in=%b busy=%b, expected ena=%b enb=%b in=%b busy=%b",
               name, got.ena, got.enb, got.pins, got.busy, exp.ena, exp.enb, exp.pins, exp.busy);
    end
  endtask

  // Reset asserted mid-cycle, between the queued stimulus and its clock edge.
  task automatic reset_pulse();
    #2;
    clr_n = 1'b0;
    exp_q.delete();
    #1;
    check_now("reset_async", '0);
    bus.ena_in = 1'b0; bus.enb_in = 1'b0; bus.in_req = 4'b0000; bus.halt = 1'b0;
    repeat (2) @(negedge clk);
    check_now("reset_hold", '0);
    clr_n = 1'b1;
    model_reset();
    apply(1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  // Monitor: one expected entry per clock once the stimulus has queued it.
  always @(posedge clk) begin
    out_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_now("cycle", e);
    end
  end

  initial begin
    logic [1:0] ra, rb;
    bus.ena_in = 1'b0; bus.enb_in = 1'b0; bus.in_req = 4'b0000; bus.halt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_now("reset_initial", '0);
    clr_n = 1'b1;
    apply(1'b0, 1'b0, 4'b0000, 1'b0);
    repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b0);
    // Start from rest, then reversal while running.
    repeat (8) step(1'b1, 1'b0, 4'b0010, 1'b0);
    repeat (7) step(1'b1, 1'b0, 4'b0001, 1'b0);
    // Brake during the ramp, then a fresh forward ramp.
    repeat (3) step(1'b1, 1'b0, 4'b0011, 1'b0);
    repeat (8) step(1'b1, 1'b0, 4'b0010, 1'b0);
    // Re-latching during dead time, expiry into STOP.
    step(1'b1, 1'b0, 4'b0001, 1'b0);
    step(1'b1, 1'b0, 4'b0010, 1'b0);
    step(1'b1, 1'b0, 4'b0001, 1'b0);
    repeat (6) step(1'b1, 1'b0, 4'b0001, 1'b0);
    repeat (4) step(1'b1, 1'b0, 4'b0001, 1'b0);
    step(1'b1, 1'b0, 4'b0010, 1'b0);
    repeat (5) step(1'b1, 1'b0, 4'b0000, 1'b0);
    // Reversal in the very cycle the ramp saturates.
    repeat (4) step(1'b1, 1'b0, 4'b0010, 1'b0);
    repeat (6) step(1'b1, 1'b0, 4'b0001, 1'b0);
    // Halt with both channels running, then release with requests held.
    repeat (10) step(1'b1, 1'b1, 4'b1010, 1'b0);
    repeat (3) step(1'b1, 1'b1, 4'b1010, 1'b1);
    repeat (10) step(1'b1, 1'b1, 4'b1010, 1'b0);
    // A reverses into DEAD while B runs, then reset during A's dead time.
    repeat (2) step(1'b1, 1'b1, 4'b1001, 1'b0);
    reset_pulse();
    repeat (8) step(1'b1, 1'b1, 4'b1001, 1'b0);
    // Randomised traffic.
    ra = 2'b00; rb = 2'b00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) ra = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) rb = 2'($urandom_range(0, 3));
      step($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, {rb, ra},
           $urandom_range(0, 39) == 0);
    end
    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hbridge_guard.md
Name: hbridge_guard

Overview:
- Sits directly downstream of the drive PWM stage, between its motor-drive outputs (ena, enb, in[3:0]) and the dual H-bridge pins.
- Inserts a dead time on every direction reversal.
- Soft-starts each motor by gating its enable with a duty ramp.
- Forces an immediate coast when the over-current halt is raised.
- Protects the bridge and gearboxes from shoot-through transients and inrush.

Parameters:
- PERIOD, 1000: gating sawtooth period in clk cycles; ramp level saturates here.
- DEAD_CYCLES, 50000: enable-low, in=00 interval on reversal (0.5 ms at 100 MHz).
- STEP_CYCLES, 100000: clk cycles between ramp level increments.
- RAMP_INC, 50: ramp level increment per step.

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- ena_in  in  1  channel A enable from PWM stage
- enb_in  in  1  channel B enable from PWM stage
- in_req  in  4  direction request; [1:0] channel A, [3:2] channel B
- halt  in  1  over-current halt, same clock domain, level
- ena  out  1  guarded channel A enable to bridge
- enb  out  1  guarded channel B enable to bridge
- in  out  4  guarded direction pins to bridge
- busy  out  2  per channel: 1 while in DEAD or RAMP

Behaviour:
- One clock domain; all inputs are synchronous to clk, so no synchronisers.
- All outputs are registered; one-cycle latency from input to output.
- Reset (clr_n low, asynchronous):
  - ena=0, enb=0, in=0000, busy=00.
  - Both channels in IDLE; ramp levels, dead counters, step counters and sawtooth at 0.
- Direction codes per pair: 2'b10 FWD, 2'b01 REV, 2'b00 coast and 2'b11 brake (together: STOP).
- Sawtooth saw: counts 0..PERIOD-1, free-running, shared by both channels.
- Per-channel FSM:
  - IDLE
    - Outputs: pair=req, en=en_in (brake and coast pass straight through); level=0.
    - On req FWD/REV: latch dir, enter RAMP.
  - RAMP
    - Outputs: pair=dir, en=en_in & (saw < level).
    - level += RAMP_INC every STEP_CYCLES, saturating at PERIOD.
    - When level reaches PERIOD: enter RUN.
  - RUN
    - Outputs: pair=dir, en=en_in.
  - Transitions from RAMP or RUN:
    - req = opposite direction: enter DEAD, load dead counter, latch new dir.
    - req = STOP: enter IDLE immediately.
    - req = same dir: stay.
  - DEAD
    - Outputs: pair=00, en=0; counts DEAD_CYCLES cycles exactly.
    - A req change during DEAD re-latches dir and does not restart the count.
    - At expiry: req FWD/REV enters RAMP with level=0 and the latched dir; req STOP enters IDLE.
- halt:
  - Overrides everything: next cycle ena=enb=0 and in=0000.
  - Both FSMs are forced to IDLE with level=0 while halt is high.
  - On release, normal IDLE behaviour resumes; a held FWD/REV starts a fresh ramp.
- Simultaneous events:
  - halt beats every transition.
  - A reversal and a ramp saturation in the same cycle: reversal wins, enter DEAD.
- Channels A and B are fully independent apart from the shared saw and halt.
- Counter widths are $clog2 of the respective parameter, plus 1 bit of headroom on level.

Decomposition:
- Shared package hbridge_pkg holds:
  - State encoding: IDLE, RAMP, RUN, DEAD.
  - DIR_FWD=2'b10, DIR_REV=2'b01, DIR_COAST=2'b00, DIR_BRAKE=2'b11.
  - A function is_move(code).
- One sub-module, hbridge_channel, is instantiated twice.
  - It holds the FSM, the dead counter, the step counter and the level.
  - It takes saw and halt as inputs.
- The top holds the sawtooth, the instantiations and the output registers.

Test Plan (PERIOD=10, DEAD_CYCLES=4, STEP_CYCLES=2, RAMP_INC=5):
1. Reset: clr_n low mid-traffic -> ena=enb=0, in=0000, busy=00 without a clk edge; after release, outputs stay 0 until a request arrives.
2. Start from rest: ena_in=1, in_req[1:0]=10 -> next cycle in[1:0]=10, busy[0]=1, ena=0 (level 0); then 5/10 duty for 2 cycles; then ena=1 constantly, busy[0]=0.
3. Reversal in RUN: in_req[1:0] 10->01 -> exactly 4 cycles of in[1:0]=00 and ena=0, then in[1:0]=01 with ramp restarting from level 0.
4. Brake in RAMP: in_req[1:0]=11 -> next cycle in[1:0]=11, ena=ena_in, busy[0]=0; a later request of 10 ramps from 0.
5. Halt: halt=1 with both channels in RUN -> next cycle ena=enb=0, in=0000; halt=0 with requests held -> both channels ramp again from 0.
6. Independence and mid-operation reset: channel A in DEAD while B is in RUN -> B unaffected; clr_n pulsed during A's DEAD -> all outputs 0 and A in IDLE.
